// File: rtl/data_memory_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// data_memory_arbiter_pkg
// Shared types and constants for the two-port data memory arbiter.
//   arb_state_t   : arbiter FSM states (idle, locked to port 0, locked to port 1)
//   port_idx_t    : requester index (0 = processor, 1 = peripheral/loader)
//   ERR_READ_DATA : data returned for a read that failed the address check
// -----------------------------------------------------------------------------
package data_memory_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_LOCK0 = 2'd1,
        ARB_LOCK1 = 2'd2
    } arb_state_t;

    typedef logic port_idx_t;

    localparam logic [31:0] ERR_READ_DATA = 32'hDEADBEEF;

    function automatic port_idx_t other_port(input port_idx_t p);
        return ~p;
    endfunction

endpackage

// File: rtl/data_memory_arbiter_if.sv
// -----------------------------------------------------------------------------
// data_memory_arbiter_if
// Bundles both requester ports and the data_memory side of the arbiter.
//   req/we/lock/addr/wdata[0|1] : requester -> arbiter
//   gnt/err/rvalid/rdata[0|1]   : arbiter -> requester
//   mem_write/mem_address/mem_write_data : arbiter -> data_memory
//   mem_read_data                        : data_memory -> arbiter
// Modport slave is the arbiter's view; master is the environment's view
// (both requesters and the memory).
// -----------------------------------------------------------------------------
interface data_memory_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req0,    req1;
    logic              we0,     we1;
    logic              lock0,   lock1;
    logic [ADDR_W-1:0] addr0,   addr1;
    logic [DATA_W-1:0] wdata0,  wdata1;
    logic              gnt0,    gnt1;
    logic              err0,    err1;
    logic              rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata0,  rdata1;

    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_read_data;

    modport slave (
        input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, err0, err1, rvalid0, rvalid1, rdata0, rdata1,
        output mem_write, mem_address, mem_write_data,
        input  mem_read_data
    );

    modport master (
        output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, err0, err1, rvalid0, rvalid1, rdata0, rdata1,
        input  mem_write, mem_address, mem_write_data,
        output mem_read_data
    );
endinterface

// File: rtl/mem_addr_check.sv
// -----------------------------------------------------------------------------
// mem_addr_check
// Combinational byte-address check for one requester.
//   i_addr : byte address from the requester
//   o_err  : 1 when the address is not word aligned or lies beyond the memory
// -----------------------------------------------------------------------------
module mem_addr_check #(
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 1024
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_err
);
    // One extra bit so the limit is representable even if it equals 2**ADDR_W.
    localparam logic [ADDR_W:0] BYTE_LIMIT = (ADDR_W+1)'(4 * MEM_WORDS);

    logic w_misaligned;
    logic w_out_of_range;

    assign w_misaligned   = (i_addr[1:0] != 2'b00);
    assign w_out_of_range = ({1'b0, i_addr} >= BYTE_LIMIT);
    assign o_err          = w_misaligned || w_out_of_range;
endmodule

// File: rtl/data_memory_arbiter.sv
// -----------------------------------------------------------------------------
// data_memory_arbiter
// Shares the single-port data memory between the processor (port 0) and the
// peripheral/loader (port 1). Round-robin on contention, optional lock for
// bursts with an idle timeout, and address range/alignment checking.
//   clk   : system clock, rising edge
//   rst_n : synchronous reset, active low
//   bus   : data_memory_arbiter_if.slave (requester ports + memory side)
// Grants are combinational from the current requests; read responses come
// back one cycle after the grant, steered by a registered response tag.
// -----------------------------------------------------------------------------
module data_memory_arbiter
    import data_memory_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_WORDS    = 1024,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    data_memory_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

    // Per-port views of the requester signals, indexed by port number.
    logic [1:0]        w_req, w_we, w_lock, w_err, w_gnt;
    logic [ADDR_W-1:0] w_addr  [2];
    logic [DATA_W-1:0] w_wdata [2];
    logic              w_gnt_any;
    port_idx_t         w_sel;
    port_idx_t         w_own;
    logic [DATA_W-1:0] w_rdata;

    arb_state_t        r_state;
    port_idx_t         r_ptr;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_rvalid;
    logic              r_rd_err;

    assign w_req      = {bus.req1,  bus.req0};
    assign w_we       = {bus.we1,   bus.we0};
    assign w_lock     = {bus.lock1, bus.lock0};
    assign w_addr[0]  = bus.addr0;
    assign w_addr[1]  = bus.addr1;
    assign w_wdata[0] = bus.wdata0;
    assign w_wdata[1] = bus.wdata1;

    for (genvar g = 0; g < 2; g++) begin : g_chk
        mem_addr_check #(
            .ADDR_W    (ADDR_W),
            .MEM_WORDS (MEM_WORDS)
        ) u_chk (
            .i_addr (w_addr[g]),
            .o_err  (w_err[g])
        );
    end

    // Grant selection. Held at zero during reset so nothing is committed.
    always_comb begin
        w_gnt = 2'b00;
        if (rst_n) begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_req[0] && w_req[1]) w_gnt[r_ptr] = 1'b1;
                    else                      w_gnt        = w_req;
                end
                ARB_LOCK0: w_gnt[0] = w_req[0];
                ARB_LOCK1: w_gnt[1] = w_req[1];
                default:   w_gnt    = 2'b00;
            endcase
        end
    end

    assign w_gnt_any = |w_gnt;
    assign w_sel     = w_gnt[1];          // grant is one-hot, so bit 1 names the port
    assign w_own     = (r_state == ARB_LOCK1);

    assign bus.gnt0  = w_gnt[0];
    assign bus.gnt1  = w_gnt[1];
    assign bus.err0  = w_gnt[0] && w_err[0];
    assign bus.err1  = w_gnt[1] && w_err[1];

    // Memory side: idle drives address 0; errored writes are suppressed.
    assign bus.mem_address    = w_gnt_any ? w_addr[w_sel] : '0;
    assign bus.mem_write      = w_gnt_any && w_we[w_sel] && !w_err[w_sel];
    assign bus.mem_write_data = (w_gnt_any && w_we[w_sel]) ? w_wdata[w_sel] : '0;

    // Arbiter FSM: state, round-robin pointer and lock idle counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
            r_ptr   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (w_gnt_any) r_ptr <= other_port(w_sel);
            case (r_state)
                ARB_IDLE: begin
                    r_cnt <= '0;
                    if (w_gnt_any && w_lock[w_sel])
                        r_state <= w_sel ? ARB_LOCK1 : ARB_LOCK0;
                end
                ARB_LOCK0, ARB_LOCK1: begin
                    if (w_req[w_own]) begin
                        // Owner is always granted while locked.
                        r_cnt <= '0;
                        if (!w_lock[w_own]) r_state <= ARB_IDLE;
                    end else if (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        // This idle cycle is the LOCK_TIMEOUT-th one: release.
                        r_state <= ARB_IDLE;
                        r_cnt   <= '0;
                        r_ptr   <= other_port(w_own);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Response tag: which port gets next cycle's read data, and whether the
    // read failed its address check (then the memory data is replaced).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rvalid <= 2'b00;
            r_rd_err <= 1'b0;
        end else begin
            r_rvalid <= w_gnt & ~w_we;
            r_rd_err <= w_gnt_any && w_err[w_sel];
        end
    end

    assign w_rdata     = r_rd_err ? DATA_W'(ERR_READ_DATA) : bus.mem_read_data;
    assign bus.rvalid0 = r_rvalid[0];
    assign bus.rvalid1 = r_rvalid[1];
    assign bus.rdata0  = r_rvalid[0] ? w_rdata : '0;
    assign bus.rdata1  = r_rvalid[1] ? w_rdata : '0;
endmodule
